// File: rtl/cmsdk_mcu_mtx4x2_ip_pkg.sv
// Shared matrix definitions: HTRANS codes, input-stage FSM encodings and the
// address/control bundle captured while a transfer waits for arbitration.
package cmsdk_mcu_mtx4x2_ip_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_PEND = 2'b01;
  localparam logic [1:0] ST_DATA = 2'b10;

  typedef struct packed {
    logic        sel;
    logic [31:0] addr;
    logic [2:0]  auser;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic [3:0]  master;
    logic        mastlock;
  } addr_ctrl_t;

  // A held SEQ may have lost bus ownership to another master, so it restarts as NONSEQ.
  function automatic logic [1:0] held_trans(input logic [1:0] trans);
    return (trans == HTRANS_SEQ) ? HTRANS_NONSEQ : trans;
  endfunction

endpackage

// File: rtl/cmsdk_mcu_mtx4x2_ip_if.sv
// Bus bundle between one AHB slave port of the matrix and its output stages.
interface cmsdk_mcu_mtx4x2_ip_if;

  logic        HSELS;
  logic [31:0] HADDRS;
  logic [2:0]  HAUSERS;
  logic [1:0]  HTRANSS;
  logic        HWRITES;
  logic [2:0]  HSIZES;
  logic [2:0]  HBURSTS;
  logic [3:0]  HPROTS;
  logic [3:0]  HMASTERS;
  logic        HMASTLOCKS;
  logic        HREADYS;
  logic        HREADYOUTS;
  logic        HRESPS;

  logic        sel_ip;
  logic [31:0] addr_ip;
  logic [2:0]  auser_ip;
  logic [1:0]  trans_ip;
  logic        write_ip;
  logic [2:0]  size_ip;
  logic [2:0]  burst_ip;
  logic [3:0]  prot_ip;
  logic [3:0]  master_ip;
  logic        mastlock_ip;
  logic        held_tran_ip;
  logic        active_ip;
  logic        readyout_ip;
  logic        resp_ip;

  modport slave (
    input  HSELS, HADDRS, HAUSERS, HTRANSS, HWRITES, HSIZES,
    input  HBURSTS, HPROTS, HMASTERS, HMASTLOCKS, HREADYS,
    output HREADYOUTS, HRESPS,
    output sel_ip, addr_ip, auser_ip, trans_ip, write_ip, size_ip,
    output burst_ip, prot_ip, master_ip, mastlock_ip, held_tran_ip,
    input  active_ip, readyout_ip, resp_ip
  );

  modport master (
    output HSELS, HADDRS, HAUSERS, HTRANSS, HWRITES, HSIZES,
    output HBURSTS, HPROTS, HMASTERS, HMASTLOCKS, HREADYS,
    input  HREADYOUTS, HRESPS,
    input  sel_ip, addr_ip, auser_ip, trans_ip, write_ip, size_ip,
    input  burst_ip, prot_ip, master_ip, mastlock_ip, held_tran_ip,
    output active_ip, readyout_ip, resp_ip
  );

endinterface

// File: rtl/cmsdk_mcu_mtx4x2_ip.sv
// Matrix input stage: holds a slave-port address phase until an output stage
// grants it, and routes the granted stage's ready/response back to the master.
module cmsdk_mcu_mtx4x2_ip
  import cmsdk_mcu_mtx4x2_ip_pkg::*;
(
  input  logic                  HCLK,
  input  logic                  HRESETn,
  cmsdk_mcu_mtx4x2_ip_if.slave  bus
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  addr_ctrl_t live;
  addr_ctrl_t hold;
  addr_ctrl_t out;
  logic       new_tran;
  logic       held_tran;
  logic       accept;
  logic       capture;

  always_comb begin
    live.sel      = bus.HSELS;
    live.addr     = bus.HADDRS;
    live.auser    = bus.HAUSERS;
    live.trans    = bus.HTRANSS;
    live.write    = bus.HWRITES;
    live.size     = bus.HSIZES;
    live.burst    = bus.HBURSTS;
    live.prot     = bus.HPROTS;
    live.master   = bus.HMASTERS;
    live.mastlock = bus.HMASTLOCKS;
  end

  // HTRANSS is ignored while a data phase is wait-stated.
  assign new_tran  = bus.HSELS & bus.HTRANSS[1] & bus.HREADYS &
                     ~((state == ST_DATA) & ~bus.readyout_ip);
  assign held_tran = (state == ST_PEND) | new_tran;
  assign accept    = held_tran & bus.active_ip & bus.readyout_ip;
  assign capture   = new_tran & ~accept & (state != ST_PEND);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (new_tran) state_nxt = accept ? ST_DATA : ST_PEND;
      end
      ST_PEND: begin
        if (accept) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (bus.readyout_ip) begin
          if (new_tran) state_nxt = accept ? ST_DATA : ST_PEND;
          else          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)     hold <= '0;
    else if (capture) hold <= live;
  end

  always_comb begin
    out = live;
    if (state == ST_PEND) begin
      out       = hold;
      out.trans = held_trans(hold.trans);
    end
  end

  assign bus.sel_ip       = out.sel;
  assign bus.addr_ip      = out.addr;
  assign bus.auser_ip     = out.auser;
  assign bus.trans_ip     = out.trans;
  assign bus.write_ip     = out.write;
  assign bus.size_ip      = out.size;
  assign bus.burst_ip     = out.burst;
  assign bus.prot_ip      = out.prot;
  assign bus.master_ip    = out.master;
  assign bus.mastlock_ip  = out.mastlock;
  assign bus.held_tran_ip = held_tran;

  always_comb begin
    bus.HREADYOUTS = 1'b1;
    bus.HRESPS     = 1'b0;
    case (state)
      ST_PEND: bus.HREADYOUTS = 1'b0;
      ST_DATA: begin
        bus.HREADYOUTS = bus.readyout_ip;
        bus.HRESPS     = bus.resp_ip;
      end
      default: ;
    endcase
  end

endmodule
